// File: rtl/glyph_pkg.sv
// Shared types and default geometry for the glyph serializer text path.
package glyph_pkg;

    // Default glyph geometry and character code width.
    localparam int GLYPH_W_DEF   = 8;
    localparam int GLYPH_H_DEF   = 8;
    localparam int CHAR_BITS_DEF = 7;

    // Serializer control states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        LOAD  = 2'd2,
        SHIFT = 2'd3
    } glyph_state_t;

endpackage

// File: rtl/glyph_serializer.sv
// Glyph serializer: accepts a character code, walks its rows through the
// synchronous font ROM and emits each row MSB-first as a 1-bit pixel stream.
module glyph_serializer
    import glyph_pkg::*;
#(
    parameter int GLYPH_W   = GLYPH_W_DEF,
    parameter int GLYPH_H   = GLYPH_H_DEF,
    parameter int CHAR_BITS = CHAR_BITS_DEF,
    localparam int ADDR_W   = $clog2((2**CHAR_BITS) * GLYPH_H)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_char_valid,
    input  logic [CHAR_BITS-1:0] i_char,
    output logic                 o_char_ready,
    output logic [ADDR_W-1:0]    o_rom_addr,
    input  logic [GLYPH_W-1:0]   i_rom_data,
    output logic                 o_pix_valid,
    output logic                 o_pix,
    output logic                 o_pix_eol,
    output logic                 o_pix_last,
    input  logic                 i_pix_ready,
    output logic                 o_busy
);

    // Row index is the low part of the ROM address; GLYPH_H is a power of 2
    // so {char,row} is exactly char*GLYPH_H+row and never overflows.
    localparam int ROW_W = $clog2(GLYPH_H);
    localparam int COL_W = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1;

    glyph_state_t          state_r, state_s;
    logic [CHAR_BITS-1:0]  char_r, char_s;
    logic [ROW_W-1:0]      row_r, row_s;
    logic [COL_W-1:0]      col_r, col_s;
    logic [GLYPH_W-1:0]    shreg_r, shreg_s;
    logic [ADDR_W-1:0]     addr_s;
    logic                  ready_s;
    logic                  pvalid_s;
    logic                  eol_s;
    logic                  last_row_s;
    logic                  pix_hs_s;

    // Pixel-side decode taken from registered state only; gated by valid so
    // every pixel qualifier is 0 whenever no pixel is being presented.
    assign eol_s       = (col_r == COL_W'(GLYPH_W - 1));
    assign last_row_s  = (row_r == ROW_W'(GLYPH_H - 1));
    assign pix_hs_s    = o_pix_valid & i_pix_ready;
    assign o_pix       = o_pix_valid & shreg_r[GLYPH_W-1];
    assign o_pix_eol   = o_pix_valid & eol_s;
    assign o_pix_last  = o_pix_valid & eol_s & last_row_s;
    assign o_busy      = (state_r != IDLE);

    // Next-state and next-register computation for the serializer FSM.
    always_comb begin
        state_s  = state_r;
        char_s   = char_r;
        row_s    = row_r;
        col_s    = col_r;
        shreg_s  = shreg_r;
        addr_s   = o_rom_addr;
        ready_s  = o_char_ready;
        pvalid_s = o_pix_valid;
        case (state_r)
            IDLE: begin
                ready_s = 1'b1;
                if (i_char_valid && o_char_ready) begin
                    char_s  = i_char;
                    row_s   = ROW_W'(0);
                    addr_s  = {i_char, ROW_W'(0)};
                    ready_s = 1'b0;
                    state_s = ADDR;
                end else begin
                    state_s = IDLE;
                end
            end
            ADDR: begin
                // ROM samples o_rom_addr on this edge; data arrives next cycle.
                state_s = LOAD;
            end
            LOAD: begin
                shreg_s  = i_rom_data;
                col_s    = COL_W'(0);
                pvalid_s = 1'b1;
                state_s  = SHIFT;
            end
            SHIFT: begin
                // Without a handshake everything holds, so a stall freezes the pixel.
                if (pix_hs_s) begin
                    shreg_s = {shreg_r[GLYPH_W-2:0], 1'b0};
                    col_s   = col_r + COL_W'(1);
                    if (eol_s && last_row_s) begin
                        pvalid_s = 1'b0;
                        ready_s  = 1'b1;
                        state_s  = IDLE;
                    end else if (eol_s) begin
                        row_s    = row_r + ROW_W'(1);
                        addr_s   = {char_r, row_r + ROW_W'(1)};
                        pvalid_s = 1'b0;
                        state_s  = ADDR;
                    end else begin
                        state_s  = SHIFT;
                    end
                end else begin
                    state_s = SHIFT;
                end
            end
            default: begin
                state_s  = IDLE;
                ready_s  = 1'b0;
                pvalid_s = 1'b0;
            end
        endcase
    end

    // State, counters, shift register and registered handshake outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r      <= IDLE;
            char_r       <= '0;
            row_r        <= '0;
            col_r        <= '0;
            shreg_r      <= '0;
            o_rom_addr   <= '0;
            o_char_ready <= 1'b0;
            o_pix_valid  <= 1'b0;
        end else begin
            state_r      <= state_s;
            char_r       <= char_s;
            row_r        <= row_s;
            col_r        <= col_s;
            shreg_r      <= shreg_s;
            o_rom_addr   <= addr_s;
            o_char_ready <= ready_s;
            o_pix_valid  <= pvalid_s;
        end
    end

endmodule

// File: tb/tb_glyph_serializer.sv
// Scoreboard bench for glyph_serializer with a behavioural synchronous font ROM.
module tb_glyph_serializer;

    logic       clk;
    logic       rst_n;
    logic       i_char_valid;
    logic [6:0] i_char;
    logic       o_char_ready;
    logic [9:0] o_rom_addr;
    logic [7:0] rom_q;
    logic       o_pix_valid;
    logic       o_pix;
    logic       o_pix_eol;
    logic       o_pix_last;
    logic       i_pix_ready;
    logic       o_busy;

    typedef struct {
        logic       pix;
        logic       eol;
        logic       last;
        logic [9:0] addr;
    } exp_t;

    exp_t exp_q[$];
    int   checks    = 0;
    int   failures  = 0;
    int   cyc       = 0;
    int   acc_cyc   = 0;
    int   acc_cnt   = 0;
    int   last_cyc  = 0;
    int   pix_in_glyph = 0;
    logic bp_en     = 1'b0;

    glyph_serializer dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_char_valid (i_char_valid),
        .i_char       (i_char),
        .o_char_ready (o_char_ready),
        .o_rom_addr   (o_rom_addr),
        .i_rom_data   (rom_q),
        .o_pix_valid  (o_pix_valid),
        .o_pix        (o_pix),
        .o_pix_eol    (o_pix_eol),
        .o_pix_last   (o_pix_last),
        .i_pix_ready  (i_pix_ready),
        .o_busy       (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Font content: 'A' at 0x41 as in the test font, a scrambled pattern elsewhere.
    function automatic logic [7:0] rom_word(input logic [9:0] a);
        logic [7:0] w;
        if (a[9:3] == 7'h41) begin
            case (a[2:0])
                3'd0:    w = 8'h18;
                3'd1:    w = 8'h24;
                3'd2:    w = 8'h42;
                3'd3:    w = 8'h7E;
                3'd4:    w = 8'h42;
                3'd5:    w = 8'h42;
                3'd6:    w = 8'h42;
                default: w = 8'h00;
            endcase
        end else begin
            w = (a[7:0] * 8'd37 + 8'd91) ^ {1'b0, a[9:3]};
        end
        return w;
    endfunction

    // Synchronous ROM: one cycle of read latency.
    always @(posedge clk) rom_q <= rom_word(o_rom_addr);

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic push_glyph(input logic [6:0] c);
        exp_t e;
        logic [7:0] w;
        for (int r = 0; r < 8; r++) begin
            w = rom_word({c, 3'(r)});
            for (int k = 0; k < 8; k++) begin
                e.pix  = w[7-k];
                e.eol  = (k == 7);
                e.last = (k == 7) && (r == 7);
                e.addr = {c, 3'(r)};
                exp_q.push_back(e);
            end
        end
    endtask

    // Edge counter; a value sampled at a negedge belongs to edge cyc+1.
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Downstream ready: steady or random back-pressure, driven after the edge.
    initial begin
        i_pix_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            i_pix_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: scoreboard pops on pixel handshakes, stall stability, accepts.
    initial begin
        logic prev_stall;
        logic h_pix, h_eol, h_last;
        exp_t e;
        prev_stall = 1'b0;
        h_pix = 1'b0; h_eol = 1'b0; h_last = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    if (o_pix_valid) begin
                        check_value("stall_pix", o_pix, h_pix);
                        check_value("stall_eol", o_pix_eol, h_eol);
                        check_value("stall_last", o_pix_last, h_last);
                    end else begin
                        check_value("valid_dropped", 32'(o_pix_valid), 32'd1);
                    end
                end
                if (o_pix_valid && i_pix_ready) begin
                    if (exp_q.size() == 0) begin
                        check_value("extra_pixel", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check_value("pix", o_pix, e.pix);
                        check_value("pix_eol", o_pix_eol, e.eol);
                        check_value("pix_last", o_pix_last, e.last);
                        if (e.eol) check_value("row_addr", o_rom_addr, e.addr);
                        pix_in_glyph++;
                        if (e.last) last_cyc = cyc + 1;
                    end
                end
                prev_stall = o_pix_valid && !i_pix_ready;
                h_pix  = o_pix;
                h_eol  = o_pix_eol;
                h_last = o_pix_last;
                if (i_char_valid && o_char_ready) begin
                    push_glyph(i_char);
                    pix_in_glyph = 0;
                    acc_cyc = cyc + 1;
                    acc_cnt++;
                end
            end
        end
    end

    task automatic wait_accept(input int start);
        int n = 0;
        while (acc_cnt == start && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (acc_cnt == start) check_value("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_char(input logic [6:0] c);
        int start;
        @(posedge clk);
        #1;
        start = acc_cnt;
        i_char = c;
        i_char_valid = 1'b1;
        wait_accept(start);
        i_char_valid = 1'b0;
        check_value("accept_addr", o_rom_addr, {c, 3'b000});
        check_value("accept_busy", o_busy, 32'd1);
        check_value("accept_ready", o_char_ready, 32'd0);
    endtask

    task automatic wait_done();
        int n = 0;
        while ((exp_q.size() != 0 || o_busy) && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 2000) check_value("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int start;
        int n;
        rst_n = 1'b0;
        i_char_valid = 1'b0;
        i_char = 7'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_value("rst_outputs", {o_char_ready, o_rom_addr, o_pix_valid, o_pix, o_pix_eol, o_pix_last, o_busy}, 32'd0);

        // Release: ready stays low until the first edge afterwards.
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        check_value("ready_cycle0", o_char_ready, 32'd0);
        check_value("valid_cycle0", o_pix_valid, 32'd0);
        @(negedge clk);
        check_value("ready_cycle1", o_char_ready, 32'd1);

        // Plain 'A' with no back-pressure: 80 cycles accept to last pixel.
        send_char(7'h41);
        wait_done();
        check_value("glyph_cycles", 32'(last_cyc - acc_cyc), 32'd80);
        check_value("idle_ready", o_char_ready, 32'd1);

        // Random back-pressure on 'A' and another character.
        bp_en = 1'b1;
        send_char(7'h41);
        wait_done();
        send_char(7'h2C);
        wait_done();
        bp_en = 1'b0;

        // Back-to-back with valid held: 'A' then 0x00; char changes mid-glyph.
        @(posedge clk);
        #1;
        start = acc_cnt;
        i_char = 7'h41;
        i_char_valid = 1'b1;
        wait_accept(start);
        i_char = 7'h00;
        wait_accept(start + 1);
        check_value("b2b_gap", 32'(acc_cyc - last_cyc), 32'd1);
        check_value("b2b_addr", o_rom_addr, 32'h000);
        i_char_valid = 1'b0;
        wait_done();

        // Reset in row 3 of 'A'.
        send_char(7'h41);
        n = 0;
        while (pix_in_glyph < 26 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (pix_in_glyph < 26) check_value("row3_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_value("midrst_outputs", {o_char_ready, o_rom_addr, o_pix_valid, o_pix, o_pix_eol, o_pix_last, o_busy}, 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        check_value("midrst_no_pix", o_pix_valid, 32'd0);
        send_char(7'h41);
        wait_done();

        // Top character: addresses end at 0x3FF with no wrap.
        bp_en = 1'b1;
        send_char(7'h7F);
        wait_done();
        bp_en = 1'b0;
        check_value("final_idle", o_busy, 32'd0);
        check_value("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
